// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared constants and helpers for the scaler line store
package scaler_pkg;

    localparam int MAX_NUM_LINES = 16;
    localparam string OREG_TRUE  = "TRUE";
    localparam string OREG_FALSE = "FALSE";

    // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// rtl/line_bank_ram.sv - one single-clock simple dual-port line bank with optional output stage
module line_bank_ram
    import scaler_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 10,
    parameter string OUTPUT_REG = "FALSE"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam bit USE_OREG = (OUTPUT_REG == OREG_TRUE);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read registers only move on an enabled read, so data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= mem_q[raddr_i];
        end
    end

    generate
        if (USE_OREG) begin : g_oreg
            logic                  re_q;
            logic [DATA_WIDTH-1:0] out_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    re_q  <= 1'b0;
                    out_q <= '0;
                end else begin
                    re_q <= re_i;
                    if (re_q) begin
                        out_q <= rd_q;
                    end
                end
            end

            assign rdata_o = out_q;
        end else begin : g_no_oreg
            assign rdata_o = rd_q;
        end
    endgenerate

endmodule

// File: rtl/line_ring_buffer.sv
// rtl/line_ring_buffer.sv - ring of line banks returning vertically adjacent pixel pairs
module line_ring_buffer
    import scaler_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 10,
    parameter int    NUM_LINES  = 4,
    parameter string OUTPUT_REG = "FALSE"
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_WIDTH:0]                 line_width,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                line_pop,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               rd_x,
    output logic                                rd_valid,
    output logic [DATA_WIDTH-1:0]               rd_data_top,
    output logic [DATA_WIDTH-1:0]               rd_data_bot,
    output logic [clog2(NUM_LINES+1)-1:0]       lines_avail
);

    localparam int PW       = clog2(NUM_LINES);
    localparam int CW       = clog2(NUM_LINES + 1);
    localparam bit USE_OREG = (OUTPUT_REG == OREG_TRUE);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_LINES - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [ADDR_WIDTH-1:0] wcol_q, wcol_d;
    logic [ADDR_WIDTH:0]   width_q, width_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         avail_q, avail_d;
    logic                  wr_ready_q, wr_ready_d;

    logic                  wr_fire, wr_last, commit, pop_ok, rd_fire;
    logic [ADDR_WIDTH:0]   width_cur;
    logic [PW-1:0]         tail_next;

    always_comb begin
        wr_fire   = wr_valid && wr_ready_q;
        // The first pixel of a line uses the live width; later pixels use the latched copy.
        width_cur = (wcol_q == '0) ? line_width : width_q;
        wr_last   = ({1'b0, wcol_q} == (width_cur - 1'b1));
        commit    = wr_fire && wr_last;
        pop_ok    = line_pop && (avail_q != '0);
        rd_fire   = rd_en && (avail_q >= CW'(2));
        tail_next = ptr_inc(tail_q);

        wcol_d  = wcol_q;
        width_d = width_q;
        head_d  = head_q;
        tail_d  = tail_q;
        avail_d = avail_q;

        if (wr_fire) begin
            wcol_d = wr_last ? '0 : wcol_q + 1'b1;
            if (wcol_q == '0) begin
                width_d = line_width;
            end
        end
        if (commit) begin
            head_d = ptr_inc(head_q);
        end
        if (pop_ok) begin
            tail_d = tail_next;
        end
        if (commit && !pop_ok) begin
            avail_d = avail_q + CW'(1);
        end else if (!commit && pop_ok) begin
            avail_d = avail_q - CW'(1);
        end

        wr_ready_d = (avail_d < CW'(NUM_LINES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcol_q     <= '0;
            width_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            avail_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            wcol_q     <= wcol_d;
            width_q    <= width_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            avail_q    <= avail_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign lines_avail = avail_q;

    logic [DATA_WIDTH-1:0] bank_rdata [NUM_LINES];

    generate
        for (genvar i = 0; i < NUM_LINES; i++) begin : g_bank
            logic bank_we, bank_re;

            assign bank_we = wr_fire && (head_q == PW'(i));
            assign bank_re = rd_fire && ((tail_q == PW'(i)) || (tail_next == PW'(i)));

            line_bank_ram #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .OUTPUT_REG (OUTPUT_REG)
            ) u_bank (
                .clk     (clk),
                .rst     (rst),
                .we_i    (bank_we),
                .waddr_i (wcol_q),
                .wdata_i (wr_data),
                .re_i    (bank_re),
                .raddr_i (rd_x),
                .rdata_o (bank_rdata[i])
            );
        end
    endgenerate

    // Bank selects travel with the read so a same-cycle pop cannot retarget the data.
    logic          v1_q;
    logic [PW-1:0] top_s1_q, bot_s1_q;
    logic [PW-1:0] sel_top, sel_bot;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            top_s1_q <= '0;
            bot_s1_q <= PW'(1);
        end else begin
            v1_q <= rd_fire;
            if (rd_fire) begin
                top_s1_q <= tail_q;
                bot_s1_q <= tail_next;
            end
        end
    end

    generate
        if (USE_OREG) begin : g_sel_oreg
            logic          v2_q;
            logic [PW-1:0] top_s2_q, bot_s2_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v2_q     <= 1'b0;
                    top_s2_q <= '0;
                    bot_s2_q <= PW'(1);
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        top_s2_q <= top_s1_q;
                        bot_s2_q <= bot_s1_q;
                    end
                end
            end

            assign rd_valid = v2_q;
            assign sel_top  = top_s2_q;
            assign sel_bot  = bot_s2_q;
        end else begin : g_sel_direct
            assign rd_valid = v1_q;
            assign sel_top  = top_s1_q;
            assign sel_bot  = bot_s1_q;
        end
    endgenerate

    assign rd_data_top = bank_rdata[sel_top];
    assign rd_data_bot = bank_rdata[sel_bot];

endmodule

// File: tb/tb_line_ring_buffer.sv
// tb/tb_line_ring_buffer.sv - directed self-checking bench for line_ring_buffer
module tb_line_ring_buffer;

    logic        clk;
    logic        rst;
    logic [10:0] line_width;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        line_pop;
    logic        rd_en;
    logic [9:0]  rd_x;

    logic        wr_ready0, rd_valid0, wr_ready1, rd_valid1;
    logic [7:0]  top0, bot0, top1, bot1;
    logic [2:0]  avail0, avail1;

    int n_checks = 0;
    int n_errors = 0;

    line_ring_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_LINES(4), .OUTPUT_REG("FALSE")) dut0 (
        .clk(clk), .rst(rst), .line_width(line_width), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_data(wr_data), .line_pop(line_pop), .rd_en(rd_en), .rd_x(rd_x), .rd_valid(rd_valid0),
        .rd_data_top(top0), .rd_data_bot(bot0), .lines_avail(avail0)
    );

    line_ring_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_LINES(4), .OUTPUT_REG("TRUE")) dut1 (
        .clk(clk), .rst(rst), .line_width(line_width), .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .wr_data(wr_data), .line_pop(line_pop), .rd_en(rd_en), .rd_x(rd_x), .rd_valid(rd_valid1),
        .rd_data_top(top1), .rd_data_bot(bot1), .lines_avail(avail1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       pop;
        logic       re;
        logic [9:0] rx;
        logic       e_rdy;
        logic [2:0] e_avail;
        logic       e_rv;
        logic       chk_data;
        logic [7:0] e_top;
        logic [7:0] e_bot;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wv, logic [7:0] wd, logic pop, logic re, logic [9:0] rx,
                                logic e_rdy, logic [2:0] e_avail, logic e_rv,
                                logic chk_data, logic [7:0] e_top, logic [7:0] e_bot);
        vec_t v;
        v.wv = wv; v.wd = wd; v.pop = pop; v.re = re; v.rx = rx;
        v.e_rdy = e_rdy; v.e_avail = e_avail; v.e_rv = e_rv;
        v.chk_data = chk_data; v.e_top = e_top; v.e_bot = e_bot;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [7:0] wd, input logic pop,
                         input logic re, input logic [9:0] rx);
        wr_valid = wv; wr_data = wd; line_pop = pop; rd_en = re; rd_x = rx;
        @(posedge clk);
        #1;
        wr_valid = 1'b0; line_pop = 1'b0; rd_en = 1'b0;
    endtask

    task automatic write_line(input int base, input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 8'(base + k), 1'b0, 1'b0, 10'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_valid = 1'b0; line_pop = 1'b0; rd_en = 1'b0; rd_x = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        line_width = 11'd8;
        do_reset();
        check("reset wr_ready", wr_ready0, 1);
        check("reset rd_valid", rd_valid0, 0);
        check("reset top", top0, 0);
        check("reset bot", bot0, 0);
        check("reset lines_avail", avail0, 0);
        check("reset oreg rd_valid", rd_valid1, 0);

        // two 8-pixel lines, a premature read, reads, hold, pops incl. pop at empty
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 8'(i), 0, (i == 8), 0, 1, (i >= 15) ? 3'd2 : (i >= 7) ? 3'd1 : 3'd0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 1, 2, 1, 1, 3, 11));
        vecs.push_back(mk(0, 0, 0, 1, 7, 1, 2, 1, 1, 7, 15));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 1, 7, 15));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1, 7, 15));

        foreach (vecs[i]) begin
            drive(vecs[i].wv, vecs[i].wd, vecs[i].pop, vecs[i].re, vecs[i].rx);
            check($sformatf("vec%0d wr_ready", i), wr_ready0, vecs[i].e_rdy);
            check($sformatf("vec%0d lines_avail", i), avail0, vecs[i].e_avail);
            check($sformatf("vec%0d rd_valid", i), rd_valid0, vecs[i].e_rv);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d top", i), top0, vecs[i].e_top);
                check($sformatf("vec%0d bot", i), bot0, vecs[i].e_bot);
            end
        end

        // fill to full, back-pressure, pop, wrap into bank 0
        do_reset();
        line_width = 11'd4;
        write_line(1, 16);
        check("full wr_ready", wr_ready0, 0);
        check("full lines_avail", avail0, 4);
        drive(1, 8'd17, 0, 0, 0);
        drive(1, 8'd17, 0, 0, 0);
        check("stall wr_ready", wr_ready0, 0);
        check("stall lines_avail", avail0, 4);
        drive(1, 8'd17, 1, 0, 0);
        check("pop wr_ready", wr_ready0, 1);
        check("pop lines_avail", avail0, 3);
        write_line(17, 4);
        check("refull lines_avail", avail0, 4);
        check("refull wr_ready", wr_ready0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 1);
        check("wrap rd_valid", rd_valid0, 1);
        check("wrap top", top0, 14);
        check("wrap bot", bot0, 18);

        // commit and pop in the same cycle
        write_line(21, 4);
        check("pre-combo lines_avail", avail0, 3);
        write_line(25, 3);
        drive(1, 8'd28, 1, 0, 0);
        check("combo lines_avail", avail0, 3);
        drive(0, 0, 0, 1, 2);
        check("combo tail top", top0, 19);
        check("combo tail bot", bot0, 23);
        write_line(29, 4);
        check("combo head lines_avail", avail0, 4);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        check("combo head top", top0, 25);
        check("combo head bot", bot0, 29);

        // pipelined reads through the output register, pop alongside the first
        write_line(33, 4);
        check("oreg pre lines_avail", avail1, 3);
        drive(0, 0, 1, 1, 0);
        check("oreg +1 rd_valid", rd_valid1, 0);
        check("direct +1 top", top0, 25);
        check("direct +1 bot", bot0, 29);
        wr_valid = 0; rd_en = 1; rd_x = 1;
        @(posedge clk); #1;
        check("oreg +2 rd_valid", rd_valid1, 1);
        check("oreg +2 top", top1, 25);
        check("oreg +2 bot", bot1, 29);
        rd_en = 1; rd_x = 2;
        @(posedge clk); #1;
        rd_en = 0;
        check("oreg +3 rd_valid", rd_valid1, 1);
        check("oreg +3 top", top1, 30);
        check("oreg +3 bot", bot1, 34);
        @(posedge clk); #1;
        check("oreg +4 rd_valid", rd_valid1, 1);
        check("oreg +4 top", top1, 31);
        check("oreg +4 bot", bot1, 35);
        @(posedge clk); #1;
        check("oreg +5 rd_valid", rd_valid1, 0);
        check("oreg hold top", top1, 31);

        // mid-line width change, then reset mid-line
        do_reset();
        line_width = 11'd8;
        write_line(100, 3);
        line_width = 11'd5;
        write_line(103, 4);
        check("width 7px lines_avail", avail0, 0);
        drive(1, 8'd107, 0, 0, 0);
        check("width 8px lines_avail", avail0, 1);
        write_line(110, 5);
        check("width next line lines_avail", avail0, 2);
        drive(0, 0, 0, 1, 4);
        check("width top", top0, 104);
        check("width bot", bot0, 114);
        write_line(120, 2);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("midreset lines_avail", avail0, 0);
        check("midreset wr_ready", wr_ready0, 1);
        check("midreset rd_valid", rd_valid0, 0);
        check("midreset top", top0, 0);
        line_width = 11'd2;
        write_line(200, 2);
        write_line(210, 2);
        check("after reset lines_avail", avail0, 2);
        drive(0, 0, 0, 1, 0);
        check("after reset top", top0, 200);
        check("after reset bot", bot0, 210);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
